mem_access_ctrl: RTL and testbench



---
 rtl/mem_access_ctrl_pkg.sv | 26 ++
 rtl/mem_access_ctrl_if.sv | 25 ++
 rtl/mem_access_ctrl.sv | 175 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared state encoding and UART address map for the memory access controller
// Purpose: access FSM states, default UART register addresses and a state-class helper.
// Ports:   none (package).
package mem_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RAM_RD,
    RAM_WR_SETUP,
    RAM_WR_PULSE,
    RAM_WR_HOLD,
    UART_WAIT,
    UART_RD,
    UART_WR,
    DONE
  } state_t;

  localparam logic [15:0] UART_DATA_ADDR_DFLT = 16'hBF00;
  localparam logic [15:0] UART_STAT_ADDR_DFLT = 16'hBF01;

  // SRAM chip enable is held across the whole RAM transaction, setup and hold included.
  function automatic logic is_ram_state(input state_t s);
    return (s == RAM_RD) || (s == RAM_WR_SETUP) || (s == RAM_WR_PULSE) || (s == RAM_WR_HOLD);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - EX/MEM request and response bus of the memory access controller
// Purpose: bundles the pipeline-side request/response handshake.
// Ports:   master = pipeline side (drives req_*), slave = controller (drives stall, resp_*).
interface mem_access_ctrl_if;

  logic        req_valid;
  logic        req_re;
  logic        req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        stall;
  logic        resp_valid;
  logic [15:0] resp_rdata;

  modport master (
    output req_valid, req_re, req_we, req_addr, req_wdata,
    input  stall, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_re, req_we, req_addr, req_wdata,
    output stall, resp_valid, resp_rdata
  );

endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - memory stage responder for data SRAM and memory-mapped UART
// Purpose: accepts a load/store from EX/MEM, stalls the pipeline while it runs the
//          SRAM or UART access, then pulses resp_valid for one cycle with the load data.
// Ports:   clk, rst            - clock, synchronous active-high reset
//          bus (slave)         - req_valid/re/we/addr/wdata in; stall, resp_valid, resp_rdata out
//          ram_*               - SRAM address, write data, bus drive enable, strobes, read data
//          uart_*              - UART strobes, RX byte, RX-ready and TX-empty flags
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned  WAIT_CYCLES    = 2,
  parameter logic [15:0]  UART_DATA_ADDR = UART_DATA_ADDR_DFLT,
  parameter logic [15:0]  UART_STAT_ADDR = UART_STAT_ADDR_DFLT
) (
  input  logic        clk,
  input  logic        rst,
  mem_access_ctrl_if.slave bus,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_wdata,
  output logic        ram_data_oe,
  input  logic [15:0] ram_rdata,
  output logic        ram_en_n,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  output logic        uart_rdn,
  output logic        uart_wrn,
  input  logic [7:0]  uart_rdata,
  input  logic        uart_data_ready,
  input  logic        uart_tbre,
  input  logic        uart_tsre
);

  // Counter counts down to zero; zero marks the last cycle of a timed state.
  localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES - 1);
  localparam logic [2:0] UART_LAST = 3'd1;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        accept;

  logic        en_n_q, oe_n_q, we_n_q, data_oe_q, rdn_q, wrn_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    accept  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid && (bus.req_re || bus.req_we)) begin
          accept = 1'b1;
          addr_d = bus.req_addr;
          if (bus.req_addr == UART_DATA_ADDR) begin
            if (bus.req_we) begin
              // Only the low byte goes to the UART; upper lines are driven low.
              wdata_d = {8'h00, bus.req_wdata[7:0]};
              state_d = UART_WAIT;
            end else begin
              state_d = UART_RD;
              cnt_d   = UART_LAST;
            end
          end else if (bus.req_addr == UART_STAT_ADDR) begin
            // Status is a snapshot taken in the accept cycle; status writes are ignored.
            if (!bus.req_we) begin
              rdata_d = {14'b0, uart_data_ready, uart_tbre & uart_tsre};
            end
            state_d = DONE;
          end else if (bus.req_we) begin
            wdata_d = bus.req_wdata;
            state_d = RAM_WR_SETUP;
          end else begin
            state_d = RAM_RD;
            cnt_d   = WAIT_LAST;
          end
        end
      end
      RAM_RD: begin
        if (cnt_q == 3'd0) begin
          rdata_d = ram_rdata;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RAM_WR_SETUP: begin
        state_d = RAM_WR_PULSE;
        cnt_d   = WAIT_LAST;
      end
      RAM_WR_PULSE: begin
        if (cnt_q == 3'd0) begin
          state_d = RAM_WR_HOLD;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RAM_WR_HOLD: state_d = DONE;
      UART_WAIT: begin
        if (uart_tbre && uart_tsre) begin
          state_d = UART_WR;
          cnt_d   = UART_LAST;
        end
      end
      UART_RD: begin
        if (cnt_q == 3'd0) begin
          rdata_d = {8'h00, uart_rdata};
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      UART_WR: begin
        if (cnt_q == 3'd0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      // DONE never accepts: the request still held in EX/MEM must not retrigger.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      addr_q    <= 16'h0000;
      wdata_q   <= 16'h0000;
      rdata_q   <= 16'h0000;
      en_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      data_oe_q <= 1'b0;
      rdn_q     <= 1'b1;
      wrn_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      // Strobes are registered decodes of the state being entered, so they are
      // glitch-free and line up exactly with the registered state.
      en_n_q    <= !is_ram_state(state_d);
      oe_n_q    <= (state_d != RAM_RD);
      we_n_q    <= (state_d != RAM_WR_PULSE);
      data_oe_q <= (state_d == RAM_WR_SETUP) || (state_d == RAM_WR_PULSE) ||
                   (state_d == RAM_WR_HOLD)  || (state_d == UART_WR);
      rdn_q     <= (state_d != UART_RD);
      wrn_q     <= (state_d != UART_WR);
    end
  end

  // The accept term freezes the pipeline in the same cycle the request is seen.
  assign bus.stall      = accept || ((state_q != IDLE) && (state_q != DONE));
  assign bus.resp_valid = (state_q == DONE);
  assign bus.resp_rdata = rdata_q;

  assign ram_addr    = addr_q;
  assign ram_wdata   = wdata_q;
  assign ram_data_oe = data_oe_q;
  assign ram_en_n    = en_n_q;
  assign ram_oe_n    = oe_n_q;
  assign ram_we_n    = we_n_q;
  assign uart_rdn    = rdn_q;
  assign uart_wrn    = wrn_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

  localparam int          W  = 2;
  localparam logic [15:0] UA = 16'hBF00;
  localparam logic [15:0] US = 16'hBF01;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ram_addr, ram_wdata, ram_rdata;
  logic        ram_data_oe, ram_en_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn;
  logic [7:0]  uart_rdata;
  logic        uart_data_ready, uart_tbre, uart_tsre;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] last_rdata = 16'h0000;

  always #5 clk = ~clk;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.WAIT_CYCLES(W)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .ram_addr        (ram_addr),
    .ram_wdata       (ram_wdata),
    .ram_data_oe     (ram_data_oe),
    .ram_rdata       (ram_rdata),
    .ram_en_n        (ram_en_n),
    .ram_oe_n        (ram_oe_n),
    .ram_we_n        (ram_we_n),
    .uart_rdn        (uart_rdn),
    .uart_wrn        (uart_wrn),
    .uart_rdata      (uart_rdata),
    .uart_data_ready (uart_data_ready),
    .uart_tbre       (uart_tbre),
    .uart_tsre       (uart_tsre)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-cycle external inputs: SRAM/UART data move every cycle so the sample point is visible.
  task automatic drive_cycle(input int k, input bit uawr, input int nwait,
                             input logic [15:0] base, input logic [7:0] ub, input logic [2:0] st0);
    ram_rdata  = base ^ 16'(k);
    uart_rdata = ub ^ 8'(k);
    if (uawr) begin
      uart_data_ready = 1'($urandom);
      uart_tbre       = (k >= nwait);
      uart_tsre       = (k >= nwait / 2);
    end else if (k == 0) begin
      {uart_data_ready, uart_tbre, uart_tsre} = st0;
    end else begin
      {uart_data_ready, uart_tbre, uart_tsre} = 3'($urandom);
    end
  endtask

  task automatic run_txn(input logic re, input logic we, input logic [15:0] addr,
                         input logic [15:0] wdata, input int nwait,
                         input logic [15:0] base, input logic [7:0] ub, input logic [2:0] st0);
    bit          is_ud, is_st, is_ram, uawr;
    int          lat, m, k;
    logic [15:0] exp_rd;
    int          stall_n, en_n, oe_n, we_n, we_first, rdn_n, rdn_first, wrn_n, wrn_first, oe_drv, bad;
    is_ud  = (addr == UA);
    is_st  = (addr == US);
    is_ram = !is_ud && !is_st;
    uawr   = is_ud && we;
    exp_rd = last_rdata;
    m      = (nwait < 1) ? 1 : nwait;
    if (is_ram && !we)     begin lat = W + 1; exp_rd = base ^ 16'(W); end
    else if (is_ram)       lat = W + 3;
    else if (is_ud && !we) begin lat = 3; exp_rd = {8'h00, ub ^ 8'd2}; end
    else if (is_ud)        lat = m + 3;
    else if (!we)          begin lat = 1; exp_rd = {14'b0, st0[2], st0[1] & st0[0]}; end
    else                   lat = 1;

    stall_n = 0; en_n = 0; oe_n = 0; we_n = 0; rdn_n = 0; wrn_n = 0; oe_drv = 0; bad = 0;
    we_first = -1; rdn_first = -1; wrn_first = -1;

    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_re = re; bus.req_we = we;
    bus.req_addr = addr;  bus.req_wdata = wdata;
    k = 0;
    drive_cycle(k, uawr, nwait, base, ub, st0);
    forever begin
      @(negedge clk);
      if (bus.resp_valid || k >= 40) break;
      if (bus.stall) stall_n++;
      if (!ram_en_n) begin en_n++; if (ram_addr !== addr) bad++; end
      if (!ram_oe_n) oe_n++;
      if (!ram_we_n) begin we_n++; if (we_first < 0) we_first = k; if (ram_wdata !== wdata) bad++; end
      if (!uart_rdn) begin rdn_n++; if (rdn_first < 0) rdn_first = k; end
      if (!uart_wrn) begin
        wrn_n++; if (wrn_first < 0) wrn_first = k;
        if (ram_wdata[7:0] !== wdata[7:0] || !ram_data_oe) bad++;
      end
      if (ram_data_oe) oe_drv++;
      @(posedge clk); #1;
      k++;
      drive_cycle(k, uawr, nwait, base, ub, st0);
    end

    check_eq("latency", k, lat);
    check_eq("stall_cycles", stall_n, lat);
    check_eq("stall_at_done", bus.stall, 1'b0);
    check_eq("strobes_at_done", {ram_en_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn, ram_data_oe}, 6'b111110);
    check_eq("resp_rdata", bus.resp_rdata, exp_rd);
    check_eq("bus_values", bad, 0);
    if (is_ram && !we) begin
      check_eq("rd_en_cycles", en_n, W);
      check_eq("rd_oe_cycles", oe_n, W);
    end else if (is_ram) begin
      check_eq("wr_en_cycles", en_n, W + 2);
      check_eq("wr_we_cycles", we_n, W);
      check_eq("wr_we_first", we_first, 2);
      check_eq("wr_oe_drive", oe_drv, W + 2);
    end else if (is_ud && !we) begin
      check_eq("uart_rd_cycles", rdn_n, 2);
      check_eq("uart_rd_first", rdn_first, 1);
    end else if (is_ud) begin
      check_eq("uart_wr_cycles", wrn_n, 2);
      check_eq("uart_wr_first", wrn_first, m + 1);
      check_eq("uart_wr_drive", oe_drv, 2);
    end else begin
      check_eq("status_no_strobe", en_n + rdn_n + wrn_n + oe_drv, 0);
    end
    last_rdata = exp_rd;
  endtask

  task automatic gap(input int n, input bit noop);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.req_valid = noop; bus.req_re = 1'b0; bus.req_we = 1'b0;
      bus.req_addr  = 16'($urandom);
      @(negedge clk);
      check_eq("gap_stall", bus.stall, 1'b0);
      check_eq("gap_resp", bus.resp_valid, 1'b0);
    end
  endtask

  function automatic logic [15:0] pick_addr();
    case ($urandom_range(0, 4))
      0:       return UA;
      1:       return US;
      2:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_re = 1'b0; bus.req_we = 1'b0;
    bus.req_addr = 16'h0; bus.req_wdata = 16'h0;
    ram_rdata = 16'h0; uart_rdata = 8'h0;
    uart_data_ready = 1'b0; uart_tbre = 1'b0; uart_tsre = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_stall", bus.stall, 1'b0);
    check_eq("rst_resp_valid", bus.resp_valid, 1'b0);
    check_eq("rst_resp_rdata", bus.resp_rdata, 16'h0);
    check_eq("rst_ram_addr", ram_addr, 16'h0);
    check_eq("rst_ram_wdata", ram_wdata, 16'h0);
    check_eq("rst_strobes", {ram_en_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn, ram_data_oe}, 6'b111110);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed cases; data lines move as base^cycle, so bases are chosen to land on the plan values.
    run_txn(1'b1, 1'b0, 16'h4000, 16'h0, 0, 16'h1234 ^ 16'(W), 8'h00, 3'b000);
    run_txn(1'b0, 1'b1, 16'h4001, 16'hBEEF, 0, 16'hAAAA, 8'h00, 3'b000);
    run_txn(1'b0, 1'b1, UA, 16'h0041, 5, 16'h0, 8'h00, 3'b000);
    run_txn(1'b1, 1'b0, US, 16'h0, 0, 16'h0, 8'h00, 3'b111);
    run_txn(1'b1, 1'b0, UA, 16'h0, 0, 16'h0, 8'h5A ^ 8'd2, 3'b000);
    run_txn(1'b0, 1'b1, US, 16'h1234, 0, 16'h0, 8'h00, 3'b000);

    // Reset during the write pulse abandons the access with no completion pulse.
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_re = 1'b0; bus.req_we = 1'b1;
    bus.req_addr = 16'h4001; bus.req_wdata = 16'hBEEF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; bus.req_valid = 1'b0;
    @(negedge clk);
    check_eq("pre_rst_we_n", ram_we_n, 1'b0);
    @(negedge clk);
    check_eq("mid_rst_we_n", ram_we_n, 1'b1);
    check_eq("mid_rst_data_oe", ram_data_oe, 1'b0);
    check_eq("mid_rst_stall", bus.stall, 1'b0);
    check_eq("mid_rst_resp", bus.resp_valid, 1'b0);
    check_eq("mid_rst_en_n", ram_en_n, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    last_rdata = 16'h0000;
    gap(3, 1'b0);
    run_txn(1'b1, 1'b0, 16'h0100, 16'h0, 0, 16'h7E57, 8'h00, 3'b000);

    // Back-to-back reads, write-wins, top-of-space address, no-op slot.
    run_txn(1'b1, 1'b0, 16'h2000, 16'h0, 0, 16'h1111, 8'h00, 3'b000);
    run_txn(1'b1, 1'b0, 16'h2001, 16'h0, 0, 16'h2222, 8'h00, 3'b000);
    run_txn(1'b1, 1'b1, 16'h3000, 16'hC0DE, 0, 16'h9999, 8'h00, 3'b000);
    run_txn(1'b1, 1'b0, 16'hFFFF, 16'h0, 0, 16'h5555, 8'h00, 3'b000);
    gap(2, 1'b1);

    for (int t = 0; t < 60; t++) begin
      logic re_r, we_r;
      {re_r, we_r} = 2'($urandom_range(1, 3));
      run_txn(re_r, we_r, pick_addr(), 16'($urandom), $urandom_range(0, 6),
              16'($urandom), 8'($urandom), 3'($urandom));
      if ($urandom_range(0, 2) == 0) gap($urandom_range(1, 3), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
